// File: rtl/spi_arb_pkg.sv
// Shared types and default sizing for the SPI transmit arbiter.
package spi_arb_pkg;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_CNTW      = 16;
  localparam int DEF_TIMEOUT   = 256;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    LATCH     = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4,
    ABORT     = 3'd5
  } arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first requesting channel strictly after ptr,
// wrapping cyclically over NUM_CH (which need not be a power of two).
module spi_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CHW    = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CHW-1:0]    ptr,
  output logic [CHW-1:0]    gnt_idx,
  output logic              gnt_vld
);

  localparam int SW = CHW + 1;

  logic [CHW-1:0] cand_s [NUM_CH];

  // cand_s[k] is the channel at distance k+1 after ptr, modulo NUM_CH
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cand
    logic [SW-1:0] sum_s;
    assign sum_s      = {1'b0, ptr} + SW'(k + 1);
    assign cand_s[k]  = (sum_s >= SW'(NUM_CH)) ? CHW'(sum_s - SW'(NUM_CH)) : sum_s[CHW-1:0];
  end

  // Scan farthest-first so the nearest requesting candidate is the one left standing
  always_comb begin
    gnt_idx = {CHW{1'b0}};
    gnt_vld = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      gnt_idx = req[cand_s[k]] ? cand_s[k] : gnt_idx;
      gnt_vld = gnt_vld | req[cand_s[k]];
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter feeding one SPI serializer from NUM_CH transmit FIFOs.
// Optional WAIT_DONE watchdog with sticky timeout_err: define SPI_ARB_TIMEOUT_EN.
module spi_tx_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int CHW       = $clog2(NUM_CH),
  parameter int CNTW      = DEF_CNTW,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           fifo_empty,
  output logic [NUM_CH-1:0]           fifo_rd_en,
  input  logic [NUM_CH*DATAWIDTH-1:0] fifo_rd_data,
  output logic [DATAWIDTH-1:0]        ser_data,
  output logic                        ser_start,
  input  logic                        ser_done,
  output logic [CHW-1:0]              grant_id,
  output logic                        busy,
  output logic [CNTW-1:0]             word_count,
  output logic                        timeout_err
);

  arb_state_t           state_r, next_state_s;
  logic [CHW-1:0]       ptr_r, pick_idx_s, grant_id_r;
  logic                 pick_vld_s, ser_done_q_r, done_evt_s, to_hit_s;
  logic [NUM_CH-1:0]    rd_en_r, rd_en_nxt_s;
  logic                 ser_start_r, start_nxt_s, busy_r, busy_nxt_s;
  logic [DATAWIDTH-1:0] ser_data_r, lat_data_s;
  logic [CNTW-1:0]      word_count_r;

  spi_rr_pick #(.NUM_CH(NUM_CH), .CHW(CHW)) u_pick (
    .req     (~fifo_empty),
    .ptr     (ptr_r),
    .gnt_idx (pick_idx_s),
    .gnt_vld (pick_vld_s)
  );

  // A level already high when waiting starts is not a completion
  assign done_evt_s = ser_done & ~ser_done_q_r;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0] to_cnt_r;
  logic           timeout_err_r;

  assign to_hit_s = (to_cnt_r == TOW'(TIMEOUT - 1));

  // Watchdog: counts cycles spent in WAIT_DONE, cleared everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= {TOW{1'b0}};
    end else if (state_r == WAIT_DONE) begin
      to_cnt_r <= to_cnt_r + TOW'(1);
    end else begin
      to_cnt_r <= {TOW{1'b0}};
    end
  end

  // Sticky abort flag, raised as ABORT is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_r <= 1'b0;
    end else if (next_state_s == ABORT) begin
      timeout_err_r <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign to_hit_s    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable && pick_vld_s) begin
          next_state_s = POP;
        end else begin
          next_state_s = IDLE;
        end
      end
      POP:   next_state_s = LATCH;
      LATCH: next_state_s = START;
      START: next_state_s = WAIT_DONE;
      WAIT_DONE: begin
        if (done_evt_s) begin
          next_state_s = IDLE;
        end else if (to_hit_s) begin
          next_state_s = ABORT;
        end else begin
          next_state_s = WAIT_DONE;
        end
      end
      ABORT:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode on the upcoming state so the strobes come out of flops
  always_comb begin
    rd_en_nxt_s = {NUM_CH{1'b0}};
    start_nxt_s = 1'b0;
    busy_nxt_s  = 1'b0;
    case (next_state_s)
      POP: begin
        rd_en_nxt_s[pick_idx_s] = 1'b1;
        busy_nxt_s              = 1'b1;
      end
      LATCH:     busy_nxt_s = 1'b1;
      START: begin
        start_nxt_s = 1'b1;
        busy_nxt_s  = 1'b1;
      end
      WAIT_DONE: busy_nxt_s = 1'b1;
      default:   busy_nxt_s = 1'b0;
    endcase
  end

  // Read-data mux for the granted channel
  always_comb begin
    lat_data_s = {DATAWIDTH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      lat_data_s = (grant_id_r == CHW'(i)) ? fifo_rd_data[i*DATAWIDTH +: DATAWIDTH] : lat_data_s;
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_done_q_r <= 1'b0;
      rd_en_r      <= {NUM_CH{1'b0}};
      ser_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      grant_id_r   <= {CHW{1'b0}};
      ser_data_r   <= {DATAWIDTH{1'b0}};
    end else begin
      ser_done_q_r <= ser_done;
      rd_en_r      <= rd_en_nxt_s;
      ser_start_r  <= start_nxt_s;
      busy_r       <= busy_nxt_s;
      if (state_r == IDLE && next_state_s == POP) begin
        grant_id_r <= pick_idx_s;
      end
      if (state_r == LATCH) begin
        ser_data_r <= lat_data_s;
      end
    end
  end

  // Round-robin pointer and completed-word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r        <= CHW'(NUM_CH - 1);
      word_count_r <= {CNTW{1'b0}};
    end else if (state_r == WAIT_DONE && done_evt_s) begin
      ptr_r        <= grant_id_r;
      word_count_r <= word_count_r + CNTW'(1);
    end else if (state_r == ABORT) begin
      ptr_r        <= grant_id_r;
    end
  end

  assign fifo_rd_en = rd_en_r;
  assign ser_start  = ser_start_r;
  assign busy       = busy_r;
  assign grant_id   = grant_id_r;
  assign ser_data   = ser_data_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: FIFO/serializer responders, a
// transaction-level reference model compared every cycle, and directed tests.
module tb_spi_tx_arbiter;

  localparam int NUM_CH  = 4;
  localparam int DW      = 32;
  localparam int CHW     = 2;
  localparam int CNTW    = 4;
  localparam int TIMEOUT = 256;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk, rst_n, enable, ser_done;
  logic [NUM_CH-1:0]    fifo_empty, fifo_rd_en;
  logic [NUM_CH*DW-1:0] fifo_rd_data;
  logic [DW-1:0]        ser_data;
  logic                 ser_start, busy, timeout_err;
  logic [CHW-1:0]       grant_id;
  logic [CNTW-1:0]      word_count;

  spi_tx_arbiter #(.NUM_CH(NUM_CH), .DATAWIDTH(DW), .CHW(CHW), .CNTW(CNTW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .ser_data(ser_data),
    .ser_start(ser_start), .ser_done(ser_done), .grant_id(grant_id), .busy(busy),
    .word_count(word_count), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- FIFO responder (1-cycle read latency) ----------------
  logic [DW-1:0] fq [NUM_CH][$];

  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (fifo_rd_en[i] && fq[i].size() > 0) fifo_rd_data[i*DW +: DW] <= fq[i].pop_front();
      fifo_empty[i] <= (fq[i].size() == 0);
    end
  end

  // ---------------- serializer responder ----------------
  bit ser_auto = 1'b1;
  bit man_done = 1'b0;
  bit auto_done;
  int ser_cnt;
  assign ser_done = ser_auto ? auto_done : man_done;

  always @(posedge clk) begin
    if (ser_start) begin
      ser_cnt   <= 3;
      auto_done <= 1'b0;
    end else if (ser_cnt == 1) begin
      ser_cnt   <= 0;
      auto_done <= 1'b1;
    end else if (ser_cnt > 1) begin
      ser_cnt   <= ser_cnt - 1;
      auto_done <= 1'b0;
    end else begin
      auto_done <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // A transfer is tracked by its age in cycles since the grant decision:
  // age 1 pop, age 2 data returns, age 3 start pulse, age >= 4 waiting for done edge.
  function automatic int rr_pick(input int ptr, input logic [NUM_CH-1:0] empt);
    for (int off = 1; off <= NUM_CH; off++)
      if (!empt[(ptr + off) % NUM_CH]) return (ptr + off) % NUM_CH;
    return 0;
  endfunction

  bit              m_busy, m_dprev, m_err, m_abort;
  int              m_age, m_ch, m_ptr, m_wait;
  logic [CNTW-1:0] m_cnt;
  logic [DW-1:0]   m_word, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_age <= 0; m_ch <= 0; m_ptr <= NUM_CH - 1; m_wait <= 0;
      m_cnt <= '0; m_word <= '0; m_pend <= '0; m_dprev <= 1'b0; m_err <= 1'b0; m_abort <= 1'b0;
    end else begin
      m_dprev <= ser_done;
      if (m_busy) begin
        if (m_age == 2) m_word <= m_pend;
        if (m_age >= 4) begin
          if (ser_done && !m_dprev) begin
            m_busy <= 1'b0; m_cnt <= m_cnt + 1'b1; m_ptr <= m_ch;
          end else if (TO_EN && m_wait == TIMEOUT - 1) begin
            m_busy <= 1'b0; m_ptr <= m_ch; m_err <= 1'b1; m_abort <= 1'b1;
          end else begin
            m_wait <= m_wait + 1;
          end
        end else begin
          m_age <= m_age + 1;
        end
      end else if (m_abort) begin
        m_abort <= 1'b0;
      end else if (enable && !(&fifo_empty)) begin
        m_busy <= 1'b1; m_age <= 1; m_wait <= 0;
        m_ch   <= rr_pick(m_ptr, fifo_empty);
        m_pend <= fq[rr_pick(m_ptr, fifo_empty)][0];
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("rd_en", fifo_rd_en, (m_busy && m_age == 1) ? (4'b0001 << m_ch) : 4'b0000);
      check("ser_start", ser_start, m_busy && m_age == 3);
      check("busy", busy, m_busy);
      check("grant_id", grant_id, m_ch);
      check("ser_data", ser_data, m_word);
      check("word_count", word_count, m_cnt);
      check("timeout_err", timeout_err, m_err);
    end
  end

  // Grant order log, one entry per pop strobe
  int glog [$];
  always @(negedge clk) begin
    if (rst_n && fifo_rd_en != '0) begin
      for (int i = 0; i < NUM_CH; i++) if (fifo_rd_en[i]) glog.push_back(i);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_cnt(input string nm, input logic [CNTW-1:0] tgt, input int bound);
    int k = 0;
    while (word_count !== tgt && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(nm, word_count, tgt);
  endtask

  task automatic wait_start(input string nm, input int bound);
    int k = 0;
    while (ser_start !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(nm, ser_start, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int k;

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", fifo_rd_en, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_ser_data", ser_data, 32'h0000_0000);
    check("rst_word_count", word_count, 4'h0);
    rst_n = 1'b1; chk_on = 1'b1;

    // Single word on ch0: pop two cycles after push, start four cycles after
    enable = 1'b1;
    @(negedge clk);
    fq[0].push_back(32'hA5A5_0001);
    k = 0;
    while (k < 20) begin
      @(negedge clk); k++;
      if (fifo_rd_en != '0) break;
    end
    check("single_rd_lat", k, 2);
    check("single_rd_en", fifo_rd_en, 4'b0001);
    while (k < 20) begin
      @(negedge clk); k++;
      if (ser_start) break;
    end
    check("single_start_lat", k, 4);
    check("single_ser_data", ser_data, 32'hA5A5_0001);
    wait_cnt("single_count", 4'd1, 40);

    // Round robin, all channels requesting
    do_reset();
    glog.delete();
    fq[0].push_back(32'h1000_0000); fq[0].push_back(32'h1000_0001);
    fq[1].push_back(32'h1111_0000); fq[2].push_back(32'h1222_0000); fq[3].push_back(32'h1333_0000);
    wait_cnt("rr_count", 4'd5, 200);
    check("rr_len", glog.size(), 5);
    check("rr_g0", glog[0], 0); check("rr_g1", glog[1], 1); check("rr_g2", glog[2], 2);
    check("rr_g3", glog[3], 3); check("rr_g4", glog[4], 0);

    // Skip empty channels: ptr parked at 0, only ch1/ch3 requesting
    do_reset();
    fq[0].push_back(32'h2000_0000);
    wait_cnt("skip_pre", 4'd1, 40);
    glog.delete();
    fq[1].push_back(32'h2111_0000); fq[3].push_back(32'h2333_0000);
    fq[1].push_back(32'h2111_0001); fq[3].push_back(32'h2333_0001);
    wait_cnt("skip_count", 4'd5, 200);
    check("skip_len", glog.size(), 4);
    check("skip_g0", glog[0], 1); check("skip_g1", glog[1], 3);
    check("skip_g2", glog[2], 1); check("skip_g3", glog[3], 3);

    // Stale done: level already high must not complete the word
    ser_auto = 1'b0; man_done = 1'b1;
    @(negedge clk);
    fq[2].push_back(32'h3222_0000);
    wait_start("stale_start", 20);
    repeat (8) @(negedge clk);
    check("stale_hold_count", word_count, 4'd5);
    check("stale_hold_busy", busy, 1'b1);
    man_done = 1'b0;
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    wait_cnt("stale_count", 4'd6, 10);

    // Enable dropped while waiting: word completes, then stays idle
    fq[1].push_back(32'h4111_0000);
    wait_start("dis_start", 20);
    @(negedge clk);
    enable = 1'b0;
    fq[0].push_back(32'h4000_0000); fq[3].push_back(32'h4333_0000);
    repeat (3) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    wait_cnt("dis_count", 4'd7, 10);
    repeat (10) @(negedge clk);
    check("dis_idle_busy", busy, 1'b0);
    check("dis_idle_rd", fifo_rd_en, 4'b0000);
    enable = 1'b1; ser_auto = 1'b1;
    wait_cnt("dis_drain", 4'd9, 100);

    // Reset in WAIT_DONE: word lost, next grant is ch0
    ser_auto = 1'b0;
    fq[1].push_back(32'h5111_0000);
    wait_start("rst_start", 20);
    repeat (2) @(negedge clk);
    fq[0].push_back(32'h5000_0000); fq[2].push_back(32'h5222_0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_grant", grant_id, 2'd0);
    check("mid_rst_data", ser_data, 32'h0000_0000);
    check("mid_rst_count", word_count, 4'd0);
    @(negedge clk);
    rst_n = 1'b1; ser_auto = 1'b1;
    glog.delete();
    wait_cnt("rst_after_count", 4'd2, 100);
    check("rst_after_g0", glog[0], 0);
    check("rst_after_g1", glog[1], 2);

    // Counter wrap: 14 more words take 2 -> 16 -> 0
    for (int c = 0; c < NUM_CH; c++)
      for (int j = 0; j < 3; j++) fq[c].push_back({8'h60, 8'(c), 16'(j)});
    fq[0].push_back(32'h6000_00AA); fq[1].push_back(32'h6111_00AA);
    wait_cnt("wrap_zero", 4'd0, 400);
    fq[2].push_back(32'h6222_00BB);
    wait_cnt("wrap_one", 4'd1, 40);

`ifdef SPI_ARB_TIMEOUT_EN
    ser_auto = 1'b0; man_done = 1'b0;
    fq[3].push_back(32'h7333_0000);
    repeat (TIMEOUT + 20) @(negedge clk);
    check("to_err", timeout_err, 1'b1);
    check("to_count", word_count, 4'd1);
    check("to_busy", busy, 1'b0);
`else
    repeat (5) @(negedge clk);
    check("no_to_err", timeout_err, 1'b0);
`endif

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
